// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl
//   Byte-addressed data memory behind a valid/ready request port, with a fixed
//   access latency. It supports byte, half and word loads and stores, sign or
//   zero extension on loads, and big- or little-endian byte order. Misaligned
//   accesses, out-of-range accesses and the reserved size are reported as errors.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   req_valid     request present
//   req_ready     idle and able to accept (registered)
//   req_write     1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = reserved
//   req_unsigned  loads: 1 = zero-extend, 0 = sign-extend
//   req_addr      byte address
//   req_wdata     store data, right-justified
//   resp_valid    one-cycle response strobe (registered)
//   resp_rdata    extended load data, 0 for stores and errors (registered)
//   resp_error    error flag qualified by resp_valid (registered)
module data_memory_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1,
  parameter bit BIG_ENDIAN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] LAT_INIT = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  logic [3:0]  latCnt;

  // Request captured at the accepting edge; inputs are ignored afterwards.
  logic        latWrite;
  logic [1:0]  latSize;
  logic        latUnsigned;
  logic [31:0] latAddr;
  logic [31:0] latWdata;

  logic [7:0]  mem [DEPTH];

  logic                  accept;
  logic                  access;
  logic                  accessErr;
  logic [ADDR_WIDTH-1:0] baseAddr;
  logic [7:0]            memByte [4];
  logic [31:0]           rawLoad;
  logic [3:0]            laneEn;
  logic [7:0]            laneData [4];

  function automatic logic isError(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) ||
           (size == 2'd1 && addr[0]) ||
           (size == 2'd2 && addr[1:0] != 2'b00) ||
           ((addr >> ADDR_WIDTH) != 32'd0);
  endfunction

  // Extension is applied to the already byte-ordered value, so the sign bit
  // is always bit 7 (byte) or bit 15 (half).
  function automatic logic [31:0] extendLoad(input logic [31:0] raw, input logic [1:0] size,
                                             input logic zeroFill);
    logic signed [7:0]  sByte;
    logic signed [15:0] sHalf;
    logic signed [31:0] ext;
    sByte = raw[7:0];
    sHalf = raw[15:0];
    ext   = raw;
    if (size == 2'd0) begin
      if (zeroFill) ext = {24'd0, raw[7:0]};
      else          ext = 32'(sByte);
    end else if (size == 2'd1) begin
      if (zeroFill) ext = {16'd0, raw[15:0]};
      else          ext = 32'(sHalf);
    end
    return ext;
  endfunction

  assign accept    = (state == IDLE) && req_valid;
  assign access    = (state == BUSY) && (latCnt == 4'd1);
  assign accessErr = isError(latSize, latAddr);
  assign baseAddr  = latAddr[ADDR_WIDTH-1:0];

  // Bytes at base+0..3; only aligned, in-range accesses use the upper lanes,
  // so the wrap of the index never matters for a committed access.
  always_comb begin
    for (int k = 0; k < 4; k++) memByte[k] = mem[baseAddr + ADDR_WIDTH'(k)];
  end

  always_comb begin
    rawLoad = '0;
    case (latSize)
      2'd0: rawLoad = {24'd0, memByte[0]};
      2'd1: rawLoad = BIG_ENDIAN ? {16'd0, memByte[0], memByte[1]}
                                 : {16'd0, memByte[1], memByte[0]};
      2'd2: rawLoad = BIG_ENDIAN ? {memByte[0], memByte[1], memByte[2], memByte[3]}
                                 : {memByte[3], memByte[2], memByte[1], memByte[0]};
      default: rawLoad = '0;
    endcase
  end

  // Store lanes: lane k is written to mem[base+k].
  always_comb begin
    laneEn = 4'b0000;
    for (int k = 0; k < 4; k++) laneData[k] = 8'd0;
    case (latSize)
      2'd0: begin
        laneEn      = 4'b0001;
        laneData[0] = latWdata[7:0];
      end
      2'd1: begin
        laneEn      = 4'b0011;
        laneData[0] = BIG_ENDIAN ? latWdata[15:8] : latWdata[7:0];
        laneData[1] = BIG_ENDIAN ? latWdata[7:0]  : latWdata[15:8];
      end
      2'd2: begin
        laneEn      = 4'b1111;
        laneData[0] = BIG_ENDIAN ? latWdata[31:24] : latWdata[7:0];
        laneData[1] = BIG_ENDIAN ? latWdata[23:16] : latWdata[15:8];
        laneData[2] = BIG_ENDIAN ? latWdata[15:8]  : latWdata[23:16];
        laneData[3] = BIG_ENDIAN ? latWdata[7:0]   : latWdata[31:24];
      end
      default: laneEn = 4'b0000;
    endcase
  end

  // Memory is never reset; a reset on the commit edge cancels the store.
  always_ff @(posedge clk) begin
    if (access && latWrite && !accessErr && !reset) begin
      for (int k = 0; k < 4; k++) begin
        if (laneEn[k]) mem[baseAddr + ADDR_WIDTH'(k)] <= laneData[k];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      latWrite    <= req_write;
      latSize     <= req_size;
      latUnsigned <= req_unsigned;
      latAddr     <= req_addr;
      latWdata    <= req_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_error <= 1'b0;
      latCnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            latCnt    <= LAT_INIT;
            req_ready <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (latCnt == 4'd1) begin
            resp_valid <= 1'b1;
            resp_error <= accessErr;
            resp_rdata <= (accessErr || latWrite) ? 32'd0
                                                  : extendLoad(rawLoad, latSize, latUnsigned);
            latCnt     <= '0;
            state      <= RESP;
          end else begin
            latCnt <= latCnt - 4'd1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_error <= 1'b0;
          latCnt     <= '0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: instance 0 is big-endian with latency 1,
// instance 1 is little-endian with latency 3. "sel" picks which one the
// shared request fields drive and whose outputs are observed.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  int          sel;

  logic        valid0, valid1;
  logic        rdy0, rdy1, rv0, rv1, err0, err1;
  logic [31:0] rd0, rd1;
  logic        reqReady, respValid, respError;
  logic [31:0] respRdata;

  assign valid0    = reqValid && (sel == 0);
  assign valid1    = reqValid && (sel == 1);
  assign reqReady  = (sel == 0) ? rdy0 : rdy1;
  assign respValid = (sel == 0) ? rv0  : rv1;
  assign respError = (sel == 0) ? err0 : err1;
  assign respRdata = (sel == 0) ? rd0  : rd1;

  data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(1), .BIG_ENDIAN(1)) dut0 (
    .clk(clk), .reset(reset), .req_valid(valid0), .req_ready(rdy0),
    .req_write(reqWrite), .req_size(reqSize), .req_unsigned(reqUnsigned),
    .req_addr(reqAddr), .req_wdata(reqWdata), .resp_valid(rv0),
    .resp_rdata(rd0), .resp_error(err0));

  data_memory_ctrl #(.ADDR_WIDTH(10), .LATENCY(3), .BIG_ENDIAN(0)) dut1 (
    .clk(clk), .reset(reset), .req_valid(valid1), .req_ready(rdy1),
    .req_write(reqWrite), .req_size(reqSize), .req_unsigned(reqUnsigned),
    .req_addr(reqAddr), .req_wdata(reqWdata), .resp_valid(rv1),
    .resp_rdata(rd1), .resp_error(err1));

  always #5 clk = ~clk;

  int nPass  = 0;
  int nTotal = 0;

  // Reference memory images, one per instance, zero at start.
  logic [7:0] modelMem [2][1024];

  typedef struct {
    int          s;
    bit          wr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expErr;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  function automatic void addVec(input int s, input bit wr, input logic [1:0] size, input bit uns,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input bit expErr);
    vec_t v;
    v.s = s; v.wr = wr; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    tbl.push_back(v);
  endfunction

  // Behavioural model: n-byte access, byte i of the value sits at address a+i
  // with big-endian meaning "first address is most significant".
  function automatic void modelAccess(input int s, input bit wr, input logic [1:0] size, input bit uns,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      output logic [31:0] rdata, output bit err);
    int n;
    int a;
    int shift;
    longint unsigned val;
    n     = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    err   = (size == 2'd3) || ((addr % n) != 0) || (addr >= 32'd1024);
    rdata = 32'd0;
    if (err) return;
    a   = int'(addr);
    val = 0;
    for (int i = 0; i < n; i++) begin
      shift = (s == 0) ? 8 * (n - 1 - i) : 8 * i;
      if (wr) modelMem[s][a + i] = 8'(wdata >> shift);
      else    val = val | (longint'(modelMem[s][a + i]) << shift);
    end
    if (!wr) begin
      if (!uns && n < 4 && val[8 * n - 1]) val = val | (64'hFFFF_FFFF & ~((64'd1 << (8 * n)) - 1));
      rdata = val[31:0];
    end
  endfunction

  // Issue one request (entered and left just after a falling edge); fields are
  // scrambled while the controller is busy.
  task automatic doTxn(input bit wr, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output bit err, output int lat);
    int n;
    reqWrite = wr; reqSize = size; reqUnsigned = uns; reqAddr = addr; reqWdata = wdata;
    reqValid = 1'b1;
    n = 0;
    while (!reqReady && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!reqReady) check("ready_timeout", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;
    lat   = -1;
    rdata = 32'd0;
    err   = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      reqValid    = 1'($urandom_range(0, 1));
      reqWrite    = 1'($urandom_range(0, 1));
      reqSize     = 2'($urandom_range(0, 3));
      reqUnsigned = 1'($urandom_range(0, 1));
      reqAddr     = $urandom;
      reqWdata    = $urandom;
      @(negedge clk);
      if (respValid) begin
        lat   = c - 1;
        rdata = respRdata;
        err   = respError;
        break;
      end
    end
    reqValid = 1'b0;
    if (lat < 0) begin
      check("resp_timeout", 32'(respValid), 32'd1);
    end else begin
      @(negedge clk);
      check("resp_one_cycle", 32'(respValid), 32'd0);
      check("ready_after_resp", 32'(reqReady), 32'd1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rdata, expRdata;
    bit          err, expErr;
    int          lat, seen, c;
    bit          wr, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    int          r;

    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 1024; a++) modelMem[s][a] = 8'd0;

    reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
    reqAddr = 32'd0; reqWdata = 32'd0; sel = 0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #1;
      check($sformatf("reset_ready_%0d", s), 32'(reqReady), 32'd1);
      check($sformatf("reset_valid_%0d", s), 32'(respValid), 32'd0);
      check($sformatf("reset_rdata_%0d", s), respRdata, 32'd0);
      check($sformatf("reset_error_%0d", s), 32'(respError), 32'd0);
    end
    sel = 0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // instance 0: big-endian, latency 1
    addVec(0, 1, 2'd2, 0, 32'h010, 32'h1122_3344, 32'h0000_0000, 0);
    addVec(0, 0, 2'd0, 0, 32'h010, 32'h0,         32'h0000_0011, 0);
    addVec(0, 0, 2'd0, 1, 32'h013, 32'h0,         32'h0000_0044, 0);
    addVec(0, 0, 2'd2, 0, 32'h010, 32'h0,         32'h1122_3344, 0);
    addVec(0, 1, 2'd1, 0, 32'h020, 32'h0000_80F0, 32'h0000_0000, 0);
    addVec(0, 0, 2'd1, 0, 32'h020, 32'h0,         32'hFFFF_80F0, 0);
    addVec(0, 0, 2'd1, 1, 32'h020, 32'h0,         32'h0000_80F0, 0);
    addVec(0, 1, 2'd0, 0, 32'h025, 32'h0000_00FF, 32'h0000_0000, 0);
    addVec(0, 0, 2'd0, 0, 32'h025, 32'h0,         32'hFFFF_FFFF, 0);
    addVec(0, 0, 2'd0, 1, 32'h025, 32'h0,         32'h0000_00FF, 0);
    addVec(0, 0, 2'd2, 0, 32'h024, 32'h0,         32'h00FF_0000, 0);
    addVec(0, 0, 2'd2, 0, 32'h022, 32'h0,         32'h0000_0000, 1);
    addVec(0, 1, 2'd2, 0, 32'h400, 32'hDEAD_BEEF, 32'h0000_0000, 1);
    addVec(0, 0, 2'd2, 0, 32'h000, 32'h0,         32'h0000_0000, 0);
    addVec(0, 0, 2'd3, 0, 32'h030, 32'h0,         32'h0000_0000, 1);
    addVec(0, 0, 2'd1, 0, 32'h021, 32'h0,         32'h0000_0000, 1);
    // instance 1: little-endian, latency 3
    addVec(1, 1, 2'd2, 0, 32'h010, 32'h1122_3344, 32'h0000_0000, 0);
    addVec(1, 0, 2'd0, 1, 32'h010, 32'h0,         32'h0000_0044, 0);
    addVec(1, 0, 2'd1, 0, 32'h012, 32'h0,         32'h0000_1122, 0);
    addVec(1, 0, 2'd0, 0, 32'h013, 32'h0,         32'h0000_0011, 0);
    addVec(1, 1, 2'd1, 0, 32'h7FE, 32'h0000_1234, 32'h0000_0000, 1);

    foreach (tbl[i]) begin
      sel = tbl[i].s;
      doTxn(tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, rdata, err, lat);
      check($sformatf("vec%0d_rdata", i), rdata, tbl[i].expRdata);
      check($sformatf("vec%0d_error", i), 32'(err), 32'(tbl[i].expErr));
      check($sformatf("vec%0d_latency", i), 32'(lat), (tbl[i].s == 0) ? 32'd1 : 32'd3);
      modelAccess(tbl[i].s, tbl[i].wr, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
                  expRdata, expErr);
    end

    // Latency 3 timing, with the next request held on req_valid throughout.
    sel = 1;
    reqWrite = 1'b0; reqSize = 2'd2; reqUnsigned = 1'b0; reqAddr = 32'h010; reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqSize = 2'd0; reqUnsigned = 1'b1;
    @(negedge clk);
    check("lat_ready_low_e0", 32'(reqReady), 32'd0);
    check("lat_resp_low_e0", 32'(respValid), 32'd0);
    @(negedge clk);
    check("lat_resp_low_e1", 32'(respValid), 32'd0);
    @(negedge clk);
    check("lat_resp_low_e2", 32'(respValid), 32'd0);
    @(negedge clk);
    check("lat_resp_high_e3", 32'(respValid), 32'd1);
    check("lat_rdata_e3", respRdata, 32'h1122_3344);
    check("lat_ready_low_e3", 32'(reqReady), 32'd0);
    @(negedge clk);
    check("lat_resp_low_e4", 32'(respValid), 32'd0);
    check("lat_ready_high_e4", 32'(reqReady), 32'd1);
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(negedge clk);
    check("held_accepted", 32'(reqReady), 32'd0);
    for (c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (respValid) break;
    end
    check("held_latency", 32'(c), 32'd3);
    check("held_rdata", respRdata, 32'h0000_0044);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (respValid) seen++;
    end
    check("held_no_duplicate", 32'(seen), 32'd0);
    check("held_ready_idle", 32'(reqReady), 32'd1);

    // Reset in the middle of a store: no response, memory unchanged.
    reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 32'h040; reqWdata = 32'hCAFE_F00D; reqValid = 1'b1;
    @(posedge clk);
    #1;
    reqValid = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_ready", 32'(reqReady), 32'd1);
    check("rst_valid", 32'(respValid), 32'd0);
    check("rst_rdata", respRdata, 32'd0);
    check("rst_error", 32'(respError), 32'd0);
    #1;
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (respValid) seen++;
    end
    check("rst_no_resp", 32'(seen), 32'd0);
    doTxn(0, 2'd2, 0, 32'h040, 32'h0, rdata, err, lat);
    check("rst_store_dropped", rdata, 32'h0000_0000);
    doTxn(0, 2'd2, 0, 32'h010, 32'h0, rdata, err, lat);
    check("rst_mem_kept", rdata, 32'h1122_3344);

    // Randomised traffic against the reference model.
    for (int s = 0; s < 2; s++) begin
      sel = s;
      for (int t = 0; t < 120; t++) begin
        wr    = 1'($urandom_range(0, 1));
        r     = $urandom_range(0, 9);
        size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        uns   = 1'($urandom_range(0, 1));
        addr  = ($urandom_range(0, 15) == 0) ? ($urandom | 32'h0000_0400)
                                             : 32'($urandom_range(0, 127));
        wdata = $urandom;
        modelAccess(s, wr, size, uns, addr, wdata, expRdata, expErr);
        doTxn(wr, size, uns, addr, wdata, rdata, err, lat);
        check($sformatf("rnd%0d_%0d_rdata", s, t), rdata, expRdata);
        check($sformatf("rnd%0d_%0d_error", s, t), 32'(err), 32'(expErr));
        check($sformatf("rnd%0d_%0d_latency", s, t), 32'(lat), (s == 0) ? 32'd1 : 32'd3);
      end
    end

    $display("%0d/%0d checks passed", nPass, nTotal);
    $finish;
  end

endmodule
